// File: rtl/bus_ram_slave.sv
// Word-addressed RAM slave for the CPU bus master port.
// Each accepted request gets WAIT_CYCLES wait states, then one registered response.
module bus_ram_slave #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] BUS_addr,
    input  logic [31:0] BUS_wdata,
    input  logic        BUS_valid,
    input  logic        BUS_mode,
    input  logic        BUS_rready,
    output logic [31:0] BUS_rdata,
    output logic        BUS_wready,
    output logic        BUS_rvalid,
    output logic        BUS_err
);

    // state  | meaning
    // IDLE   | waiting for BUS_valid; latches the request
    // WAIT   | counting down wait states; access happens when cnt reaches 0
    // RESP   | response presented (wready pulse or rvalid held until rready)
    // DONE   | waiting for BUS_valid to drop so a held request runs only once
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [32:0] SPAN     = 33'd4 << AW;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_mode;

    logic [31:0] mem [0:(1<<AW)-1];

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          do_access;

    // The subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign off       = lat_addr - BASE_ADDR;
    assign in_range  = ({1'b0, off} < SPAN);
    assign idx       = off[AW+1:2];
    assign do_access = (state == S_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (do_access && lat_mode && in_range) begin
            mem[idx] <= lat_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_mode   <= 1'b0;
            BUS_rdata  <= 32'd0;
            BUS_wready <= 1'b0;
            BUS_rvalid <= 1'b0;
            BUS_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (BUS_valid) begin
                        lat_addr  <= BUS_addr;
                        lat_wdata <= BUS_wdata;
                        lat_mode  <= BUS_mode;
                        cnt       <= CNT_LOAD;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        BUS_err <= !in_range;
                        if (lat_mode) begin
                            BUS_wready <= 1'b1;
                        end else begin
                            BUS_rvalid <= 1'b1;
                            BUS_rdata  <= in_range ? mem[idx] : ERR_DATA;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (lat_mode) begin
                        BUS_wready <= 1'b0;
                        BUS_err    <= 1'b0;
                        state      <= S_DONE;
                    end else if (BUS_rready) begin
                        BUS_rvalid <= 1'b0;
                        BUS_err    <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!BUS_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
